// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-entry elastic pipeline register (skid buffer) with a
//               valid/ready handshake on both sides. i_ready and o_valid are
//               decoded from registered state only, which breaks the
//               combinational o_ready -> i_ready path between stages.
//               A synchronous flush empties the buffer for branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [DW-1:0] i_data,
    output logic          o_valid,
    input  logic          o_ready,
    output logic [DW-1:0] o_data
);

    // Occupancy states: nothing held, main valid, main and skid valid
    localparam logic [1:0] c_st_empty = 2'd0;
    localparam logic [1:0] c_st_busy  = 2'd1;
    localparam logic [1:0] c_st_full  = 2'd2;

    logic [1:0]    state_q;
    logic [1:0]    state_d;
    logic [DW-1:0] main_q;
    logic [DW-1:0] main_d;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] skid_d;

    logic          w_in_xfer;
    logic          w_out_xfer;

    assign w_in_xfer  = i_valid & i_ready;
    assign w_out_xfer = o_valid & o_ready;

    // State and data registers; reset clears everything asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_st_empty;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Next-state decode; flush overrides every transition
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = c_st_empty;
        end else begin
            case (state_q)
                c_st_empty: begin
                    if (w_in_xfer) state_d = c_st_busy;
                end
                c_st_busy: begin
                    if (w_in_xfer && !w_out_xfer)      state_d = c_st_full;
                    else if (!w_in_xfer && w_out_xfer) state_d = c_st_empty;
                end
                c_st_full: begin
                    if (w_out_xfer) state_d = c_st_busy;
                end
                default: state_d = c_st_empty;
            endcase
        end
    end

    // Data-register write selection; registers hold unless a word moves in.
    // On flush the contents become don't-care, so nothing is loaded.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (!flush) begin
            case (state_q)
                c_st_empty: begin
                    if (w_in_xfer) main_d = i_data;
                end
                c_st_busy: begin
                    // Pass-through refills main; otherwise overflow goes to skid
                    if (w_in_xfer && w_out_xfer)  main_d = i_data;
                    else if (w_in_xfer)           skid_d = i_data;
                end
                c_st_full: begin
                    if (w_out_xfer) main_d = skid_q;
                end
                default: begin
                    main_d = main_q;
                end
            endcase
        end
    end

    // Handshake outputs decoded from registered state only
    always_comb begin
        o_valid = (state_q != c_st_empty);
        i_ready = (state_q != c_st_full);
        o_data  = main_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_skid_buf
// Description : Directed self-checking bench for pipe_skid_buf, followed by a
//               randomized valid/ready run checked against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;

    int checks;
    int errors;

    pipe_skid_buf #(.DW(DW)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic ir, input logic [31:0] od);
        check({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, ov});
        check({tag, ".i_ready"}, {31'd0, i_ready}, {31'd0, ir});
        if (ov) check({tag, ".o_data"}, o_data, od);
    endtask

    logic [DW-1:0] q[$];
    logic          pending;
    logic          in_fire;
    logic          out_fire;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hDEADBEEF;
        o_ready = 1'b0;

        // Reset held with a valid offer: nothing is taken
        step();
        step();
        check("rst.o_valid", {31'd0, o_valid}, 32'd0);
        check("rst.i_ready", {31'd0, i_ready}, 32'd1);
        check("rst.o_data",  o_data, 32'h0);

        // First word after release appears one cycle later
        rst    = 1'b0;
        i_data = 32'h11;
        step();
        expect_out("first", 1'b1, 1'b1, 32'h11);
        i_valid = 1'b0;
        o_ready = 1'b1;
        step();
        expect_out("drain1", 1'b0, 1'b1, 32'h0);

        // Empty: o_ready is ignored
        step();
        expect_out("empty_ordy", 1'b0, 1'b1, 32'h0);

        // Streaming at one word per cycle
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1;
            i_data  = k;
            step();
            expect_out($sformatf("stream%0d", k), 1'b1, 1'b1, k);
        end
        i_valid = 1'b0;
        step();
        expect_out("stream_end", 1'b0, 1'b1, 32'h0);

        // Backpressure: A, B fill the buffer, C waits upstream
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        step();
        expect_out("bp_a", 1'b1, 1'b1, 32'hA);
        i_data = 32'hB;
        step();
        expect_out("bp_b", 1'b1, 1'b0, 32'hA);
        i_data = 32'hC;
        step();
        expect_out("bp_hold", 1'b1, 1'b0, 32'hA);
        step();
        expect_out("bp_hold2", 1'b1, 1'b0, 32'hA);
        o_ready = 1'b1;
        step();
        expect_out("bp_outA", 1'b1, 1'b1, 32'hB);
        step();
        expect_out("bp_outB", 1'b1, 1'b1, 32'hC);
        i_valid = 1'b0;
        step();
        expect_out("bp_outC", 1'b0, 1'b1, 32'h0);

        // Flush in FULL with a simultaneous offer
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'hA;
        step();
        i_data = 32'hB;
        step();
        expect_out("fl_full", 1'b1, 1'b0, 32'hA);
        i_data = 32'hC;
        flush  = 1'b1;
        step();
        expect_out("fl_after", 1'b0, 1'b1, 32'h0);
        flush   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b1;
        step();
        expect_out("fl_quiet1", 1'b0, 1'b1, 32'h0);
        step();
        expect_out("fl_quiet2", 1'b0, 1'b1, 32'h0);

        // Flush in BUSY with a simultaneous in- and out-transfer
        i_valid = 1'b1;
        i_data  = 32'h77;
        step();
        expect_out("flb_busy", 1'b1, 1'b1, 32'h77);
        i_data = 32'h78;
        flush  = 1'b1;
        step();
        expect_out("flb_after", 1'b0, 1'b1, 32'h0);
        flush   = 1'b0;
        i_valid = 1'b0;
        step();
        expect_out("flb_quiet", 1'b0, 1'b1, 32'h0);

        // Asynchronous reset between edges while FULL
        o_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 32'h5;
        step();
        i_data = 32'h6;
        step();
        expect_out("ar_full", 1'b1, 1'b0, 32'h5);
        #2;
        rst = 1'b1;
        #1;
        check("ar.o_valid", {31'd0, o_valid}, 32'd0);
        check("ar.i_ready", {31'd0, i_ready}, 32'd1);
        check("ar.o_data",  o_data, 32'h0);
        i_data = 32'h9;
        step();
        expect_out("ar_held", 1'b0, 1'b1, 32'h0);
        rst     = 1'b0;
        i_valid = 1'b0;
        step();
        expect_out("ar_rel", 1'b0, 1'b1, 32'h0);

        // Randomized valid/ready run against a queue model
        pending = 1'b0;
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            check("rnd.o_valid", {31'd0, o_valid}, {31'd0, (q.size() != 0)});
            check("rnd.i_ready", {31'd0, i_ready}, {31'd0, (q.size() < 2)});
            if (q.size() != 0) check("rnd.o_data", o_data, q[0]);
            if (!pending) begin
                i_valid = ($urandom_range(0, 3) != 0);
                i_data  = $urandom;
            end
            o_ready = ($urandom_range(0, 2) != 0);
            #1;
            // i_ready must not react to o_ready within the cycle
            check("rnd.i_ready_stable", {31'd0, i_ready}, {31'd0, (q.size() < 2)});
            in_fire  = i_valid & i_ready;
            out_fire = o_valid & o_ready;
            @(posedge clk);
            if (out_fire && q.size() != 0) void'(q.pop_front());
            if (in_fire) q.push_back(i_data);
            pending = i_valid & ~in_fire;
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
